// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter.
// Sends one frame per accepted request: a start bit, 8 data bits LSB first,
// an optional parity bit, then one stop bit. Each bit lasts uart_brr_i+1
// clock cycles. The divisor, data byte and parity settings are captured when
// the request is accepted, so later changes do not affect a frame in flight.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   send_start_i  transmit request, level-sampled while idle
//   send_data_i   byte to transmit, captured in the accept cycle
//   uart_brr_i    baud divisor (bit period = value + 1 cycles)
//   uart_cr_i     control: [0] UE enable, [4] PCE parity enable, [5] PS odd parity
//   txd_o         serial line, idle high
//   busy_o        high while a frame is in progress
//   tc_o          one-cycle pulse when a frame completes normally
module uart_tx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        send_start_i,
  input  logic [7:0]  send_data_i,
  input  logic [15:0] uart_brr_i,
  input  logic [5:0]  uart_cr_i,
  output logic        txd_o,
  output logic        busy_o,
  output logic        tc_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state;
  logic [7:0]  shift;
  logic [15:0] brr;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        pce;
  logic        par_bit;
  logic        ue;
  logic        bit_end;
  logic        unused_cr;

  assign ue        = uart_cr_i[0];
  assign bit_end   = (baud_cnt == 16'd0);
  assign unused_cr = ^uart_cr_i[3:1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      shift    <= 8'd0;
      brr      <= 16'd0;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      pce      <= 1'b0;
      par_bit  <= 1'b0;
      txd_o    <= 1'b1;
      busy_o   <= 1'b0;
      tc_o     <= 1'b0;
    end else begin
      tc_o <= 1'b0;
      if (state != S_IDLE && !ue) begin
        // Transmitter disabled mid-frame: drop the frame silently.
        state    <= S_IDLE;
        baud_cnt <= 16'd0;
        bit_cnt  <= 3'd0;
        txd_o    <= 1'b1;
        busy_o   <= 1'b0;
      end else begin
        // The baud counter reloads at every bit boundary; the state case
        // below only acts on the boundary cycle.
        if (state != S_IDLE) begin
          baud_cnt <= bit_end ? brr : baud_cnt - 16'd1;
        end
        case (state)
          S_IDLE: begin
            txd_o  <= 1'b1;
            busy_o <= 1'b0;
            if (send_start_i && ue) begin
              shift    <= send_data_i;
              // Parity is resolved at accept time so PS is effectively latched.
              par_bit  <= (^send_data_i) ^ uart_cr_i[5];
              pce      <= uart_cr_i[4];
              brr      <= uart_brr_i;
              baud_cnt <= uart_brr_i;
              bit_cnt  <= 3'd0;
              state    <= S_START;
              txd_o    <= 1'b0;
              busy_o   <= 1'b1;
            end
          end
          S_START: begin
            if (bit_end) begin
              state <= S_DATA;
              txd_o <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end
          S_DATA: begin
            if (bit_end) begin
              if (bit_cnt == 3'd7) begin
                state <= pce ? S_PARITY : S_STOP;
                txd_o <= pce ? par_bit : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                txd_o   <= shift[0];
                shift   <= {1'b0, shift[7:1]};
              end
            end
          end
          S_PARITY: begin
            if (bit_end) begin
              state <= S_STOP;
              txd_o <= 1'b1;
            end
          end
          S_STOP: begin
            if (bit_end) begin
              state  <= S_IDLE;
              txd_o  <= 1'b1;
              busy_o <= 1'b0;
              tc_o   <= 1'b1;
            end
          end
          default: begin
            state  <= S_IDLE;
            txd_o  <= 1'b1;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
